// File: rtl/masked_pkg.sv
// Shared definitions for the masked serial adder: share count, default
// operand width and the controller state encoding.
package masked_pkg;

  // Two Boolean shares per secret bit (x = s0 ^ s1).
  localparam int NUM_SHARES = 2;

  // Default operand / sum width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Controller states of the bit-serial adder.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/masked_full_adder.sv
// Two-share masked full-adder slice built from two masked half-adders.
// HA1 adds the operand bits, HA2 adds the incoming carry to their partial
// sum. The two generate terms can never both be 1, so the carry-out is
// their XOR, which keeps the combination linear and share-wise.
module masked_full_adder
  import masked_pkg::*;
(
  input  logic [NUM_SHARES-1:0] a,
  input  logic [NUM_SHARES-1:0] b,
  input  logic [NUM_SHARES-1:0] cin,
  input  logic [1:0]            rnd,
  output logic [NUM_SHARES-1:0] s,
  output logic [NUM_SHARES-1:0] cout
);

  logic [NUM_SHARES-1:0] p;
  logic [NUM_SHARES-1:0] g1;
  logic [NUM_SHARES-1:0] g2;

  masked_half_adder u_ha1 (
    .a (a),
    .b (b),
    .r (rnd[0]),
    .s (p),
    .g (g1)
  );

  masked_half_adder u_ha2 (
    .a (p),
    .b (cin),
    .r (rnd[1]),
    .s (s),
    .g (g2)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHARES; gi = gi + 1) begin : g_cout
      assign cout[gi] = g1[gi] ^ g2[gi];
    end
  endgenerate

endmodule

// File: rtl/masked_half_adder.sv
// Two-share masked half-adder.
// The sum is linear, so it is computed share by share. The carry (a AND b)
// uses a refreshed share multiplication: the random bit r is folded in
// before any cross-share product, so no intermediate equals an unmasked
// value.
module masked_half_adder
  import masked_pkg::*;
(
  input  logic [NUM_SHARES-1:0] a,
  input  logic [NUM_SHARES-1:0] b,
  input  logic                  r,
  output logic [NUM_SHARES-1:0] s,
  output logic [NUM_SHARES-1:0] g
);

  logic cross_0;
  logic cross_1;

  // Linear XOR per share, then masked AND with r absorbed first into share 1.
  always_comb begin
    s       = a ^ b;
    cross_0 = r ^ (a[0] & b[1]);
    cross_1 = cross_0 ^ (a[1] & b[0]);
    g[0]    = (a[0] & b[0]) ^ r;
    g[1]    = (a[1] & b[1]) ^ cross_1;
  end

endmodule

// File: rtl/masked_serial_adder.sv
// Bit-serial adder on two-share Boolean-masked operands.
// One masked full-adder slice is reused LSB first, one bit per RUN cycle;
// the carry shares are registered between bits so no combinational share
// path spans two bit positions. Operands and results stay shared throughout.
module masked_serial_adder
  import masked_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_s0,
  input  logic [WIDTH-1:0] a_s1,
  input  logic [WIDTH-1:0] b_s0,
  input  logic [WIDTH-1:0] b_s1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       rnd,
  output logic             rnd_req,
  output logic [WIDTH-1:0] sum_s0,
  output logic [WIDTH-1:0] sum_s1,
  output logic             cout_s0,
  output logic             cout_s1,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]      a_s0_q, a_s0_d;
  logic [WIDTH-1:0]      a_s1_q, a_s1_d;
  logic [WIDTH-1:0]      b_s0_q, b_s0_d;
  logic [WIDTH-1:0]      b_s1_q, b_s1_d;
  logic [WIDTH-1:0]      sum_s0_q, sum_s0_d;
  logic [WIDTH-1:0]      sum_s1_q, sum_s1_d;
  logic [NUM_SHARES-1:0] carry_q, carry_d;

  logic [NUM_SHARES-1:0] fa_a;
  logic [NUM_SHARES-1:0] fa_b;
  logic [NUM_SHARES-1:0] fa_s;
  logic [NUM_SHARES-1:0] fa_cout;
  logic [1:0]            fa_rnd;

  // Select the current bit's shares; randomness only reaches the slice in RUN.
  always_comb begin
    fa_a   = {a_s1_q[idx_q], a_s0_q[idx_q]};
    fa_b   = {b_s1_q[idx_q], b_s0_q[idx_q]};
    fa_rnd = (state_q == ST_RUN) ? rnd : 2'b00;
  end

  masked_full_adder u_slice (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .rnd  (fa_rnd),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers; reset clears every share immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_s0_q   <= '0;
      a_s1_q   <= '0;
      b_s0_q   <= '0;
      b_s1_q   <= '0;
      sum_s0_q <= '0;
      sum_s1_q <= '0;
      carry_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_s0_q   <= a_s0_d;
      a_s1_q   <= a_s1_d;
      b_s0_q   <= b_s0_d;
      b_s1_q   <= b_s1_d;
      sum_s0_q <= sum_s0_d;
      sum_s1_q <= sum_s1_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH bit steps in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)          state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: if (out_ready)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on acceptance, one sum bit and carry per RUN cycle.
  always_comb begin
    idx_d    = idx_q;
    a_s0_d   = a_s0_q;
    a_s1_d   = a_s1_q;
    b_s0_d   = b_s0_q;
    b_s1_d   = b_s1_q;
    sum_s0_d = sum_s0_q;
    sum_s1_d = sum_s1_q;
    carry_d  = carry_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_s0_d   = a_s0;
      a_s1_d   = a_s1;
      b_s0_d   = b_s0;
      b_s1_d   = b_s1;
      sum_s0_d = '0;
      sum_s1_d = '0;
      carry_d  = '0;
      idx_d    = '0;
    end else if (state_q == ST_RUN) begin
      sum_s0_d[idx_q] = fa_s[0];
      sum_s1_d[idx_q] = fa_s[1];
      carry_d         = fa_cout;
      idx_d           = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Handshake outputs decoded from state; ready is held low while in reset.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && rst_n;
    rnd_req   = (state_q == ST_RUN);
    out_valid = (state_q == ST_DONE);
  end

  assign sum_s0  = sum_s0_q;
  assign sum_s1  = sum_s1_q;
  assign cout_s0 = carry_q[0];
  assign cout_s1 = carry_q[1];

endmodule

// File: tb/tb_masked_serial_adder.sv
// Directed self-checking bench for masked_serial_adder (WIDTH = 8).
// Operand shares use fresh random masks; results are unmasked here only.
module tb_masked_serial_adder;

  localparam int W = 8;
  localparam int RUNS = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_s0, a_s1, b_s0, b_s1;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   rnd;
  logic         rnd_req;
  logic [W-1:0] sum_s0, sum_s1;
  logic         cout_s0, cout_s1;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  masked_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_s0      (a_s0),
    .a_s1      (a_s1),
    .b_s0      (b_s0),
    .b_s1      (b_s1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd       (rnd),
    .rnd_req   (rnd_req),
    .sum_s0    (sum_s0),
    .sum_s1    (sum_s1),
    .cout_s0   (cout_s0),
    .cout_s1   (cout_s1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present freshly masked operands and wait for the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = W'($urandom);
    mb = W'($urandom);
    a_s0 = a ^ ma;
    a_s1 = ma;
    b_s0 = b ^ mb;
    b_s1 = mb;
    rnd = 2'($urandom);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_s0 = W'($urandom);
    a_s1 = W'($urandom);
    b_s0 = W'($urandom);
    b_s1 = W'($urandom);
  endtask

  // Count cycles from acceptance to out_valid, bounded, with fresh rnd each cycle.
  task automatic wait_done(output int lat, output int nrnd);
    lat = 0;
    nrnd = 0;
    while (out_valid !== 1'b1 && lat < 4 * W) begin
      if (rnd_req === 1'b1) nrnd++;
      rnd = 2'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat, nrnd;
    start_op(a, b);
    wait_done(lat, nrnd);
    check({name, "_latency"}, lat, W);
    check({name, "_rnd_cycles"}, nrnd, W);
    check({name, "_sum"}, sum_s0 ^ sum_s1, exp_sum);
    check({name, "_cout"}, cout_s0 ^ cout_s1, exp_cout);
    check({name, "_done_rnd_req"}, rnd_req, 1'b0);
    check({name, "_done_in_ready"}, in_ready, 1'b0);
    $display("txn %s: A=0x%02h B=0x%02h sum=0x%02h cout=%0d latency=%0d",
             name, a, b, sum_s0 ^ sum_s1, cout_s0 ^ cout_s1, lat);
    finish_op();
    check({name, "_back_idle_ready"}, in_ready, 1'b1);
    check({name, "_back_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat, nrnd, bad;
    int ones_s0[W];
    int ones_s1[W];
    int ones_c0, ones_c1;
    logic [2*W+1:0] snap;

    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    rnd = 2'b11;
    a_s0 = 8'h5A; a_s1 = 8'hC3; b_s0 = 8'h11; b_s1 = 8'h77;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rnd_req", rnd_req, 1'b0);
    check("rst_sum", {sum_s0, sum_s1}, '0);
    check("rst_cout", {cout_s0, cout_s1}, 2'b00);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    $display("txn reset: released, in_ready=%0d", in_ready);

    // Directed additions
    run_checked("a3_b5", 8'd3, 8'd5, 8'd8, 1'b0);
    run_checked("a255_b1", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_checked("a0_b0", 8'h00, 8'h00, 8'h00, 1'b0);
    run_checked("a80_b80", 8'h80, 8'h80, 8'h00, 1'b1);
    run_checked("aff_bff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // Back-pressure in DONE: outputs hold, input pulse ignored
    start_op(8'h5A, 8'h21);
    wait_done(lat, nrnd);
    check("hold_latency", lat, W);
    snap = {sum_s0, sum_s1, cout_s0, cout_s1};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_s0 = 8'hFF; a_s1 = 8'h00; b_s0 = 8'hFF; b_s1 = 8'h00;
        in_valid = 1'b1;
      end
      rnd = 2'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_outputs", {sum_s0, sum_s1, cout_s0, cout_s1}, snap);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
    end
    check("hold_sum", sum_s0 ^ sum_s1, 8'h7B);
    check("hold_cout", cout_s0 ^ cout_s1, 1'b0);
    $display("txn hold: A=0x5a B=0x21 held 5 cycles, sum=0x%02h", sum_s0 ^ sum_s1);
    finish_op();
    check("hold_back_idle", in_ready, 1'b1);

    // Asynchronous reset while bit 4 is being processed
    start_op(8'hC3, 8'h4E);
    repeat (4) begin
      rnd = 2'($urandom);
      @(posedge clk);
      #1;
    end
    check("midrun_rnd_req", rnd_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum", {sum_s0, sum_s1}, '0);
    check("midrun_rst_cout", {cout_s0, cout_s1}, 2'b00);
    check("midrun_rst_out_valid", out_valid, 1'b0);
    check("midrun_rst_in_ready", in_ready, 1'b0);
    check("midrun_rst_rnd_req", rnd_req, 1'b0);
    $display("txn midrun_reset: outputs cleared");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrun_release_ready", in_ready, 1'b1);
    run_checked("a10_b20", 8'd10, 8'd20, 8'd30, 1'b0);

    // Fixed operands, many random masks: correctness and share balance
    bad = 0;
    ones_c0 = 0;
    ones_c1 = 0;
    for (int k = 0; k < W; k++) begin
      ones_s0[k] = 0;
      ones_s1[k] = 0;
    end
    for (int r = 0; r < RUNS; r++) begin
      start_op(8'hA5, 8'h3C);
      wait_done(lat, nrnd);
      if (lat != W || (sum_s0 ^ sum_s1) !== 8'hE1 || (cout_s0 ^ cout_s1) !== 1'b0) bad++;
      for (int k = 0; k < W; k++) begin
        ones_s0[k] += int'(sum_s0[k]);
        ones_s1[k] += int'(sum_s1[k]);
      end
      ones_c0 += int'(cout_s0);
      ones_c1 += int'(cout_s1);
      finish_op();
    end
    check("bal_bad_runs", bad, 0);
    for (int k = 0; k < W; k++) begin
      check($sformatf("bal_sum_s0_bit%0d_ones%0d", k, ones_s0[k]),
            (ones_s0[k] >= 450 && ones_s0[k] <= 550) ? 1 : 0, 1);
      check($sformatf("bal_sum_s1_bit%0d_ones%0d", k, ones_s1[k]),
            (ones_s1[k] >= 450 && ones_s1[k] <= 550) ? 1 : 0, 1);
    end
    check($sformatf("bal_cout_s0_ones%0d", ones_c0), (ones_c0 >= 450 && ones_c0 <= 550) ? 1 : 0, 1);
    check($sformatf("bal_cout_s1_ones%0d", ones_c1), (ones_c1 >= 450 && ones_c1 <= 550) ? 1 : 0, 1);
    $display("txn balance: %0d runs of 0xa5+0x3c, bad=%0d cout_s0 ones=%0d cout_s1 ones=%0d",
             RUNS, bad, ones_c0, ones_c1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
